clk_div_monitor: RTL and testbench

- Downstream checker for the divide-by-N clock generators, such as the divide-by-3 stage. It consumes the divided output as a level signal synchronous to the source clock.
- Measures the period and high time of every divided cycle in source-clock cycles and compares each measurement against programmed expected values.
- Reports lock, a sticky error flag and a saturating error count, for bring-up and on-chip self-check of divider stages.

---
 rtl/clk_div_monitor_pkg.sv | 18 +
 rtl/div_period_meter.sv | 101 ++++++++++
 rtl/clk_div_monitor.sv | 153 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_monitor_pkg.sv
// rtl/clk_div_monitor_pkg.sv - shared types and constants for the divided-clock monitor
//
// Purpose: monitor FSM state encoding and the default divide ratio used by the
//          divide-by-3 stage this monitor was first built to check.
// Ports:   none (package).

package clk_div_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_ACQ  = 2'd2,
      ST_LOCK = 2'd3
   } mon_state_e;

   localparam int unsigned DIV3_PERIOD = 3;

endpackage

// File: rtl/div_period_meter.sv
// rtl/div_period_meter.sv - edge detector, period/high counters and measurement capture
//
// Purpose: times each divided cycle in source-clock cycles, rise to rise.
// Ports:
//   clk, rst       source clock, async active-low reset
//   div_i          divided clock under check (synchronous level)
//   cnt_en_i       0 holds both counters at 0
//   cnt_hold_i     1 freezes counters except that a rise restarts them at 1
//   meas_en_i      allows a rise to publish period_o/high_o
//   rise_o         rising edge of div_i this cycle
//   per_cnt_o      cycles since last rise (saturating), hi_cnt_o high cycles since last rise
//   per_sat_o      per_cnt_o is at its ceiling
//   period_o, high_o, meas_valid_o   registered measurement and its one-cycle strobe

module div_period_meter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_i,
   input  logic             cnt_en_i,
   input  logic             cnt_hold_i,
   input  logic             meas_en_i,
   output logic             rise_o,
   output logic [CNT_W-1:0] per_cnt_o,
   output logic [CNT_W-1:0] hi_cnt_o,
   output logic             per_sat_o,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             meas_valid_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             div_q;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             meas_valid_q, meas_valid_d;
   logic             take;

   assign rise_o    = div_i & ~div_q;
   assign per_sat_o = (per_cnt_q == CNT_MAX);
   assign take      = meas_en_i & rise_o;

   always_comb begin
      per_cnt_d    = per_cnt_q;
      hi_cnt_d     = hi_cnt_q;
      period_d     = period_q;
      high_d       = high_q;
      meas_valid_d = take;

      if (!cnt_en_i) begin
         per_cnt_d = '0;
         hi_cnt_d  = '0;
      end else if (rise_o) begin
         // The rise cycle itself is the first cycle of the new period and is high.
         per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         hi_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (!cnt_hold_i) begin
         if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + 1'b1;
         end
         if (div_i && (hi_cnt_q != CNT_MAX)) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
         end
      end

      // Counters still hold the just-finished period at the rise, before restarting.
      if (take) begin
         period_d = per_cnt_q;
         high_d   = hi_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q        <= 1'b0;
         per_cnt_q    <= '0;
         hi_cnt_q     <= '0;
         period_q     <= '0;
         high_q       <= '0;
         meas_valid_q <= 1'b0;
      end else begin
         div_q        <= div_i;
         per_cnt_q    <= per_cnt_d;
         hi_cnt_q     <= hi_cnt_d;
         period_q     <= period_d;
         high_q       <= high_d;
         meas_valid_q <= meas_valid_d;
      end
   end

   assign per_cnt_o    = per_cnt_q;
   assign hi_cnt_o     = hi_cnt_q;
   assign period_o     = period_q;
   assign high_o       = high_q;
   assign meas_valid_o = meas_valid_q;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - lock/error checker for divide-by-N clock stages
//
// Purpose: compares every measured divided cycle against the programmed period and
//          high time, declares lock after LOCK_CNT consecutive matches, flags errors.
// Ports:
//   clk, rst               source clock, async active-low reset
//   en                     monitor enable; 0 returns to IDLE
//   div_in                 divided clock under check
//   exp_period, exp_high   expected period / high time in clk cycles
//   clr_err                clears err and err_cnt
//   period_out, high_out   last measurement; meas_valid pulses when they update
//   locked                 lock indication
//   err, err_cnt           sticky error flag and saturating count of errors raised in LOCK

module clk_div_monitor
   import clk_div_monitor_pkg::*;
#(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             div_in,
   input  logic [CNT_W-1:0] exp_period,
   input  logic [CNT_W-1:0] exp_high,
   input  logic             clr_err,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned      GW      = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_CNT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   mon_state_e       state_q, state_d;
   logic [GW-1:0]    good_q, good_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic             rise;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hi_cnt;
   logic             per_sat;
   logic             match;
   logic             err_ev;

   div_period_meter #(
      .CNT_W (CNT_W)
   ) u_meter (
      .clk          (clk),
      .rst          (rst),
      .div_i        (div_in),
      .cnt_en_i     (en && (state_q != ST_IDLE)),
      .cnt_hold_i   (state_q == ST_ARM),
      .meas_en_i    (en && ((state_q == ST_ACQ) || (state_q == ST_LOCK))),
      .rise_o       (rise),
      .per_cnt_o    (per_cnt),
      .hi_cnt_o     (hi_cnt),
      .per_sat_o    (per_sat),
      .period_o     (period_out),
      .high_o       (high_out),
      .meas_valid_o (meas_valid)
   );

   // A saturated period is never a valid match, even if exp_period is all ones.
   assign match = (per_cnt == exp_period) && (hi_cnt == exp_high) && !per_sat;

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_ev  = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               // First rise only opens a period; nothing to measure yet.
               if (rise) begin
                  state_d = ST_ACQ;
                  good_d  = '0;
               end
            end
            ST_ACQ: begin
               if (rise) begin
                  if (!match) begin
                     good_d = '0;
                  end else if (good_q == GOOD_LAST) begin
                     state_d = ST_LOCK;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end
            end
            ST_LOCK: begin
               // Stopped divider: a saturated period with no rise counts as one error;
               // ACQ ignores saturation so it is not counted again.
               if ((rise && !match) || (!rise && per_sat)) begin
                  err_ev  = 1'b1;
                  state_d = ST_ACQ;
                  good_d  = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // An error in the same cycle as clr_err wins and restarts the count at 1.
   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (err_ev) begin
         err_d = 1'b1;
         if (clr_err) begin
            err_cnt_d = {{(ERR_W-1){1'b0}}, 1'b1};
         end else if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
         end
      end else if (clr_err) begin
         err_d     = 1'b0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         good_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         good_q    <= good_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign locked  = (state_q == ST_LOCK);
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - self-checking bench for clk_div_monitor

module tb_clk_div_monitor;
   import clk_div_monitor_pkg::*;

   localparam int LOCK_N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       div_in = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] exp_period = 8'd3;
   logic [7:0] exp_high = 8'd1;
   logic [7:0] period_out, high_out, err_cnt;
   logic       meas_valid, locked, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_div_monitor #(.CNT_W(8), .LOCK_CNT(LOCK_N), .ERR_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .div_in     (div_in),
      .exp_period (exp_period),
      .exp_high   (exp_high),
      .clr_err    (clr_err),
      .period_out (period_out),
      .high_out   (high_out),
      .meas_valid (meas_valid),
      .locked     (locked),
      .err        (err),
      .err_cnt    (err_cnt)
   );

   // Reference model: time-stamps of rises and counted high cycles
   int m_phase, m_last, m_hi, m_streak, m_period, m_high, m_cnt, m_t;
   bit m_prev, m_locked, m_err, m_mv;

   task automatic model_reset();
      m_phase = 0; m_last = 0; m_hi = 0; m_streak = 0; m_period = 0; m_high = 0;
      m_cnt = 0; m_prev = 0; m_locked = 0; m_err = 0; m_mv = 0;
   endtask

   task automatic model_step(input bit e, input bit d, input bit c, input int ep, input int eh);
      bit r, match, ev;
      int per;
      r = d && !m_prev;
      ev = 0;
      m_mv = 0;
      if (!e) begin
         m_phase = 0; m_locked = 0; m_streak = 0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (r) begin m_phase = 2; m_last = m_t; m_hi = 1; end
      end else begin
         per = m_t - m_last;
         if (per > 255) per = 255;
         if (r) begin
            match = (per == ep) && (m_hi == eh) && (per < 255);
            m_period = per; m_high = m_hi; m_mv = 1;
            if (m_locked) begin
               if (!match) begin ev = 1; m_locked = 0; m_streak = 0; end
            end else if (match) begin
               m_streak++;
               if (m_streak == LOCK_N) begin m_locked = 1; m_streak = 0; end
            end else begin
               m_streak = 0;
            end
            m_last = m_t; m_hi = 1;
         end else begin
            if (d && m_hi < 255) m_hi++;
            if (m_locked && per == 255) begin ev = 1; m_locked = 0; m_streak = 0; end
         end
      end
      if (ev) begin
         m_err = 1;
         m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (c) begin
         m_err = 0; m_cnt = 0;
      end
      m_prev = d;
      m_t++;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic step(input bit d, input bit c);
      div_in = d;
      clr_err = c;
      model_step(en, d, c, int'(exp_period), int'(exp_high));
      @(posedge clk);
      #1;
      checks++;
      if (period_out !== 8'(m_period) || high_out !== 8'(m_high) || meas_valid !== m_mv ||
          locked !== m_locked || err !== m_err || err_cnt !== 8'(m_cnt)) begin
         errors++;
         $display("FAIL model t=%0d: got per=%0d hi=%0d mv=%0b lk=%0b err=%0b cnt=%0d expected per=%0d hi=%0d mv=%0b lk=%0b err=%0b cnt=%0d",
                  m_t, period_out, high_out, meas_valid, locked, err, err_cnt,
                  m_period, m_high, m_mv, m_locked, m_err, m_cnt);
      end
   endtask

   logic       r_mv, r_lk, r_er;
   logic [7:0] r_per, r_high, r_cnt;

   // One divided cycle: lo zeros then hi ones; snapshot outputs right after the rise.
   task automatic apply_row(input int lo, input int hi, input bit c);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
      step(1'b1, c);
      r_mv = meas_valid; r_per = period_out; r_high = high_out;
      r_lk = locked; r_er = err; r_cnt = err_cnt;
      for (int i = 1; i < hi; i++) step(1'b1, 1'b0);
   endtask

   typedef struct {
      int lo; int hi;
      bit mv; int per; int high; bit lk; bit er; int cnt;
   } row_t;

   row_t rows[12];

   initial begin
      int first_err, mv_seen, lo, hi;

      rows[0]  = '{2, 1, 1'b0, 0, 0, 1'b0, 1'b0, 0};
      rows[1]  = '{2, 2, 1'b1, 3, 1, 1'b0, 1'b0, 0};
      rows[2]  = '{1, 1, 1'b1, 3, 2, 1'b0, 1'b0, 0};
      rows[3]  = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b0, 0};
      rows[4]  = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b0, 0};
      rows[5]  = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b0, 0};
      rows[6]  = '{2, 1, 1'b1, 3, 1, 1'b1, 1'b0, 0};
      rows[7]  = '{3, 1, 1'b1, 4, 1, 1'b0, 1'b1, 1};
      rows[8]  = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b1, 1};
      rows[9]  = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b1, 1};
      rows[10] = '{2, 1, 1'b1, 3, 1, 1'b0, 1'b1, 1};
      rows[11] = '{2, 1, 1'b1, 3, 1, 1'b1, 1'b1, 1};

      model_reset();
      m_t = 0;
      exp_period = 8'(DIV3_PERIOD);
      exp_high = 8'd1;
      #12;
      chk("reset period_out", period_out, 0);
      chk("reset high_out", high_out, 0);
      chk("reset meas_valid", meas_valid, 0);
      chk("reset locked", locked, 0);
      chk("reset err", err, 0);
      chk("reset err_cnt", err_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      en = 1'b1;

      // Lock, acquisition mismatch, LOCK mismatch, relock
      for (int i = 0; i < 12; i++) begin
         apply_row(rows[i].lo, rows[i].hi, 1'b0);
         chk($sformatf("row%0d meas_valid", i), r_mv, rows[i].mv);
         if (rows[i].mv) begin
            chk($sformatf("row%0d period_out", i), r_per, rows[i].per);
            chk($sformatf("row%0d high_out", i), r_high, rows[i].high);
         end
         chk($sformatf("row%0d locked", i), r_lk, rows[i].lk);
         chk($sformatf("row%0d err", i), r_er, rows[i].er);
         chk($sformatf("row%0d err_cnt", i), r_cnt, rows[i].cnt);
      end

      // Clear while locked, then stop the divider
      step(1'b0, 1'b1);
      chk("clr err", err, 0);
      chk("clr err_cnt", err_cnt, 0);
      first_err = 0;
      mv_seen = 0;
      for (int k = 1; k <= 300; k++) begin
         step(1'b0, 1'b0);
         if (meas_valid) mv_seen++;
         if (first_err == 0 && err_cnt != 0) first_err = k;
      end
      chk("stop timeout step", first_err, 254);
      chk("stop err_cnt once", err_cnt, 1);
      chk("stop locked", locked, 0);
      chk("stop meas_valid count", mv_seen, 0);

      // Build err_cnt up to 5, then collide clr_err with a LOCK mismatch
      for (int it = 0; it < 4; it++) begin
         for (int j = 0; j < 5; j++) apply_row(2, 1, 1'b0);
         apply_row(3, 1, 1'b0);
      end
      chk("collide pre err_cnt", err_cnt, 5);
      for (int j = 0; j < 5; j++) apply_row(2, 1, 1'b0);
      chk("collide pre locked", locked, 1);
      apply_row(3, 1, 1'b1);
      chk("collide err", r_er, 1);
      chk("collide err_cnt", r_cnt, 1);
      chk("collide locked", r_lk, 0);
      chk("collide period", r_per, 4);

      // Enable drop while locked
      for (int j = 0; j < 5; j++) apply_row(2, 1, 1'b0);
      chk("endrop pre locked", locked, 1);
      en = 1'b0;
      step(1'b0, 1'b0);
      chk("endrop locked", locked, 0);
      chk("endrop err kept", err, 1);
      chk("endrop err_cnt kept", err_cnt, 1);
      chk("endrop period kept", period_out, 3);
      chk("endrop high kept", high_out, 1);
      en = 1'b1;
      apply_row(2, 1, 1'b0);
      chk("rearm first rise no meas", r_mv, 0);
      apply_row(2, 1, 1'b0);
      chk("rearm meas", r_mv, 1);

      // Asynchronous reset mid-period
      step(1'b0, 1'b0);
      #3 rst = 1'b0;
      #1;
      chk("async period_out", period_out, 0);
      chk("async high_out", high_out, 0);
      chk("async meas_valid", meas_valid, 0);
      chk("async locked", locked, 0);
      chk("async err", err, 0);
      chk("async err_cnt", err_cnt, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // Randomized traffic against the reference model
      for (int s = 0; s < 400; s++) begin
         int sel;
         sel = $urandom_range(0, 29);
         if (sel == 0) begin
            en = 1'b0;
            step(1'b0, 1'b0);
            step(1'($urandom_range(0, 1)), 1'b0);
            exp_period = 8'($urandom_range(2, 6));
            exp_high = 8'($urandom_range(1, int'(exp_period) - 1));
            en = 1'b1;
         end else if (sel == 1) begin
            step(1'b0, 1'b1);
         end else if (sel == 2 && s % 100 == 2) begin
            for (int k = 0; k < 270; k++) step(1'b0, 1'($urandom_range(0, 40) == 0));
         end else begin
            lo = int'(exp_period) - int'(exp_high);
            hi = int'(exp_high);
            if ($urandom_range(0, 9) == 0) lo = lo + $urandom_range(1, 2);
            if ($urandom_range(0, 9) == 0) hi = hi + 1;
            apply_row(lo, hi, 1'($urandom_range(0, 15) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
